ring_pattern_checker: RTL and testbench

//  Downstream monitor for the 8-bit rotating-ring register: samples ring word every enabled cycle,

---
 rtl/ring_pattern_checker_pkg.sv | 32 +++
 rtl/ring_onehot_enc.sv | 25 ++
 rtl/ring_pattern_checker.sv | 147 ++++++++++++++
 tb/tb_ring_pattern_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pattern_checker_pkg.sv
// rtl/ring_pattern_checker_pkg.sv - shared types, defaults and next-word predictor for the ring checker
package ring_pattern_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    localparam int unsigned LOCK_CNT_DEF = 4;
    localparam int unsigned CNT_W_DEF    = 16;

    // MSB is carried unchanged; bits width-2:0 rotate right with bit 0 wrapping to width-2.
    function automatic logic [31:0] ring_pred(input logic [31:0] prev, input int width);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 31; i++) begin
            if (i + 2 < width) begin
                res[i] = prev[i+1];
            end else if (i + 2 == width) begin
                res[i] = prev[0];
            end else if (i + 1 == width) begin
                res[i] = prev[i];
            end
        end
        if (width == 32) begin
            res[31] = prev[31];
        end
        return res;
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// rtl/ring_onehot_enc.sv - one-hot to index encoder with exactly-one-bit legality flag
module ring_onehot_enc #(
    parameter int unsigned N  = 7,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          legal
);

    int unsigned ones;

    always_comb begin
        idx  = '0;
        ones = 0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                ones = ones + 1;
                idx  = PW'(i);
            end
        end
        legal = (ones == 1);
    end

endmodule

// File: rtl/ring_pattern_checker.sv
// rtl/ring_pattern_checker.sv - locks onto a rotating one-hot ring and reports errors, rotations and position
module ring_pattern_checker
    import ring_pattern_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    localparam int unsigned PW      = $clog2(WIDTH - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] ring_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] rot_cnt,
    output logic [PW-1:0]    pos
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               prev_v_q, prev_v_d;
    logic [3:0]         match_cnt_q, match_cnt_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [CNT_W-1:0]   rot_q, rot_d;
    logic [CNT_W-1:0]   err_q, err_d, err_base;
    logic               flag_q, flag_d;
    logic               pulse_q, pulse_d;
    logic               locked_q, locked_d;

    logic [31:0]        pred_full;
    logic [WIDTH-1:0]   pred;
    logic [PW-1:0]      enc_idx;
    logic               legal;
    logic               match;

    ring_onehot_enc #(
        .N  (WIDTH - 1),
        .PW (PW)
    ) u_enc (
        .onehot (ring_in[WIDTH-2:0]),
        .idx    (enc_idx),
        .legal  (legal)
    );

    assign pred_full = ring_pred(32'(prev_q), WIDTH);
    assign pred      = pred_full[WIDTH-1:0];
    assign match     = prev_v_q & legal & (ring_in == pred);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prev_v_d    = prev_v_q;
        match_cnt_d = match_cnt_q;
        pos_d       = pos_q;
        rot_d       = rot_q;
        pulse_d     = 1'b0;
        // clr acts first so a same-cycle locked mismatch still leaves a count of one
        err_base    = clr ? '0 : err_q;
        err_d       = err_base;
        flag_d      = clr ? 1'b0 : flag_q;

        if (!en) begin
            state_d  = ST_IDLE;
            prev_v_d = 1'b0;
        end else begin
            prev_d   = ring_in;
            prev_v_d = 1'b1;
            if (legal) begin
                pos_d = enc_idx;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_ACQUIRE;
                    match_cnt_d = '0;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        if (({1'b0, match_cnt_q} + 5'd1) == 5'(LOCK_CNT)) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 4'd1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        if (ring_in[0]) begin
                            rot_d = rot_q + CNT_W'(1);
                        end
                    end else begin
                        pulse_d     = 1'b1;
                        flag_d      = 1'b1;
                        if (err_base != '1) begin
                            err_d = err_base + CNT_W'(1);
                        end
                        state_d     = ST_ACQUIRE;
                        match_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            prev_v_q    <= 1'b0;
            match_cnt_q <= '0;
            pos_q       <= '0;
            rot_q       <= '0;
            err_q       <= '0;
            flag_q      <= 1'b0;
            pulse_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_v_q    <= prev_v_d;
            match_cnt_q <= match_cnt_d;
            pos_q       <= pos_d;
            rot_q       <= rot_d;
            err_q       <= err_d;
            flag_q      <= flag_d;
            pulse_q     <= pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_flag  = flag_q;
    assign err_cnt   = err_q;
    assign rot_cnt   = rot_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_ring_pattern_checker.sv
// tb/tb_ring_pattern_checker.sv - directed and randomized self-checking bench for ring_pattern_checker
module tb_ring_pattern_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  ring_in = 8'h00;

    logic        locked, err_pulse, err_flag;
    logic [15:0] err_cnt, rot_cnt;
    logic [2:0]  pos;
    logic        locked2, err_pulse2, err_flag2;
    logic [1:0]  err_cnt2, rot_cnt2;
    logic [2:0]  pos2;

    ring_pattern_checker #(.WIDTH(8), .LOCK_CNT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ring_in(ring_in),
        .locked(locked), .err_pulse(err_pulse), .err_flag(err_flag),
        .err_cnt(err_cnt), .rot_cnt(rot_cnt), .pos(pos)
    );

    ring_pattern_checker #(.WIDTH(8), .LOCK_CNT(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ring_in(ring_in),
        .locked(locked2), .err_pulse(err_pulse2), .err_flag(err_flag2),
        .err_cnt(err_cnt2), .rot_cnt(rot_cnt2), .pos(pos2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0] m_prev;
    bit         m_valid, m_locked, m_pulse, m_flag;
    int         m_streak, m_rot, m_err, m_err2, m_pos;

    function automatic int popc7(input logic [7:0] w);
        int n = 0;
        for (int i = 0; i < 7; i++) n += int'(w[i]);
        return n;
    endfunction

    function automatic int idx7(input logic [7:0] w);
        int k = 0;
        for (int i = 0; i < 7; i++) if (w[i]) k = i;
        return k;
    endfunction

    // Position of the set bit steps down by one each cycle, modulo 7.
    function automatic logic [7:0] nxt(input logic [7:0] w);
        logic [7:0] r;
        int k;
        k = (idx7(w) + 6) % 7;
        r = 8'(1 << k);
        r[7] = w[7];
        return r;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_prev = 8'h00; m_valid = 0; m_locked = 0; m_pulse = 0; m_flag = 0;
        m_streak = 0; m_rot = 0; m_err = 0; m_err2 = 0; m_pos = 0;
    endtask

    task automatic model_step(input bit e, input bit c, input logic [7:0] w);
        bit legal, good;
        m_pulse = 0;
        if (c) begin
            m_err = 0; m_err2 = 0; m_flag = 0;
        end
        if (!e) begin
            m_valid  = 0;
            m_locked = 0;
        end else begin
            legal = (popc7(w) == 1);
            good  = m_valid && legal && (popc7(m_prev) == 1) && (w[7] == m_prev[7])
                    && (idx7(w) == (idx7(m_prev) + 6) % 7);
            if (m_locked) begin
                if (good) begin
                    if (w[0]) m_rot = (m_rot + 1) % 65536;
                end else begin
                    m_pulse = 1; m_flag = 1;
                    if (m_err < 65535) m_err++;
                    if (m_err2 < 3) m_err2++;
                    m_locked = 0; m_streak = 0;
                end
            end else if (m_valid) begin
                if (good) begin
                    m_streak++;
                    if (m_streak == 4) begin m_locked = 1; m_streak = 0; end
                end else begin
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            if (legal) m_pos = idx7(w);
            m_prev  = w;
            m_valid = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},   int'(locked),    int'(m_locked));
        chk({tag, ".pulse"},    int'(err_pulse), int'(m_pulse));
        chk({tag, ".flag"},     int'(err_flag),  int'(m_flag));
        chk({tag, ".err_cnt"},  int'(err_cnt),   m_err);
        chk({tag, ".rot_cnt"},  int'(rot_cnt),   m_rot);
        chk({tag, ".pos"},      int'(pos),       m_pos);
        chk({tag, ".err_cnt2"}, int'(err_cnt2),  m_err2);
        chk({tag, ".rot_cnt2"}, int'(rot_cnt2),  m_rot % 4);
    endtask

    task automatic step(input bit e, input bit c, input logic [7:0] w, input string tag);
        en = e; clr = c; ring_in = w;
        @(posedge clk);
        #1;
        model_step(e, c, w);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1; en = 0; clr = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check_all(tag);
    endtask

    task automatic feed_good(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1, 0, nxt(m_prev), tag);
    endtask

    initial begin
        logic [7:0] seq1 [5];
        seq1[0] = 8'hC0; seq1[1] = 8'hA0; seq1[2] = 8'h90; seq1[3] = 8'h88; seq1[4] = 8'h84;

        model_reset();
        do_reset("reset");
        chk("reset.locked_lit", int'(locked), 0);

        // acquisition and lock
        for (int i = 0; i < 5; i++) step(1, 0, seq1[i], "t1");
        chk("t1.locked_lit", int'(locked), 1);
        chk("t1.pos_lit", int'(pos), 2);

        // full rotation counting
        feed_good(8, "t2");
        chk("t2.rot_lit", int'(rot_cnt), 1);

        // locked mismatch, then relock
        step(1, 0, 8'h84, "t3.bad");
        chk("t3.pulse_lit", int'(err_pulse), 1);
        chk("t3.err_lit", int'(err_cnt), 1);
        feed_good(3, "t3.acq");
        chk("t3.pulse_gone", int'(err_pulse), 0);
        chk("t3.not_yet", int'(locked), 0);
        feed_good(1, "t3.relock");
        chk("t3.relocked", int'(locked), 1);

        // saturation on the 2-bit instance
        step(1, 1, nxt(m_prev), "t4.clr");
        for (int k = 0; k < 5; k++) begin
            step(1, 0, m_prev, "t4.bad");
            feed_good(4, "t4.relock");
        end
        chk("t4.sat_lit", int'(err_cnt2), 3);
        step(1, 1, nxt(m_prev), "t4.clr2");
        chk("t4.clr_lit", int'(err_cnt2), 0);

        // enable gap drops to idle and needs fresh matches
        for (int k = 0; k < 3; k++) step(0, 0, 8'h00, "t5.gap");
        feed_good(4, "t5.acq");
        chk("t5.not_yet", int'(locked), 0);
        feed_good(1, "t5.relock");

        // two errors, reset mid-lock, illegal word in acquire
        step(1, 0, m_prev, "t6.bad1");
        feed_good(4, "t6.relock1");
        step(1, 0, m_prev, "t6.bad2");
        feed_good(4, "t6.relock2");
        chk("t6.err2_lit", int'(err_cnt), 2);
        do_reset("t6.rst");
        chk("t6.err_rst_lit", int'(err_cnt), 0);
        step(1, 0, 8'hC0, "t6.a");
        step(1, 0, 8'hA0, "t6.b");
        step(1, 0, 8'h86, "t6.illegal");
        chk("t6.pos_hold", int'(pos), 5);
        step(1, 0, 8'h90, "t6.after");

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [7:0] w;
            r = int'($urandom_range(0, 99));
            w = (popc7(m_prev) == 1) ? nxt(m_prev) : 8'hC0;
            if (r < 1) begin
                do_reset("rnd.rst");
            end else if (r < 6) begin
                step(0, 0, 8'($urandom), "rnd.gap");
            end else if (r < 11) begin
                step(1, 0, 8'($urandom), "rnd.any");
            end else if (r < 13) begin
                w[7] = ~w[7];
                step(1, 0, w, "rnd.msb");
            end else if (r < 16) begin
                step(1, 1, w, "rnd.clr");
            end else begin
                step(1, 0, w, "rnd.good");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
